// File: rtl/ex_div.sv
// Iterative 32-bit integer divider for the EX stage: DIV/DIVU/REM/REMU.
// Uses radix-2 restoring steps, one per clock, and bypasses the loop for divide-by-zero and signed overflow.
module ex_div (
    input  logic        clk,
    input  logic        rest,
    input  logic        ex2div_start_i,
    input  logic [1:0]  ex2div_op_i,
    input  logic [31:0] ex2div_dividend_i,
    input  logic [31:0] ex2div_divisor_i,
    input  logic [4:0]  ex2div_rd_addr_i,
    input  logic        ex2div_flush_i,
    output logic        div2ex_busy_o,
    output logic        div2ex_ready_o,
    output logic [31:0] div2ex_result_o,
    output logic [4:0]  div2ex_rd_addr_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        in_signed, in_rem, a_neg, b_neg, div_zero, overflow;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted, trial;
    logic [31:0] step_quot, step_rem, final_quot, final_rem;

    // op[0]=1 selects unsigned, op[1]=1 selects remainder.
    assign in_signed = ~ex2div_op_i[0];
    assign in_rem    = ex2div_op_i[1];
    assign a_neg     = in_signed & ex2div_dividend_i[31];
    assign b_neg     = in_signed & ex2div_divisor_i[31];
    assign a_mag     = a_neg ? (~ex2div_dividend_i + 32'd1) : ex2div_dividend_i;
    assign b_mag     = b_neg ? (~ex2div_divisor_i + 32'd1) : ex2div_divisor_i;
    assign div_zero  = (ex2div_divisor_i == 32'd0);
    assign overflow  = in_signed && (ex2div_dividend_i == 32'h8000_0000)
                       && (ex2div_divisor_i == 32'hFFFF_FFFF);

    // Partial remainder is always below the divisor, so the 33-bit trial sign decides the quotient bit.
    assign shifted    = {rem_q, quot_q[31]};
    assign trial      = shifted - {1'b0, divisor_q};
    assign step_quot  = {quot_q[30:0], ~trial[32]};
    assign step_rem   = trial[32] ? shifted[31:0] : trial[31:0];
    assign final_quot = neg_quot_q ? (~step_quot + 32'd1) : step_quot;
    assign final_rem  = neg_rem_q ? (~step_rem + 32'd1) : step_rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rd_d       = rd_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        case (state_q)
            IDLE: begin
                if (ex2div_start_i && !ex2div_flush_i) begin
                    rd_d     = ex2div_rd_addr_i;
                    is_rem_d = in_rem;
                    if (div_zero) begin
                        result_d = in_rem ? ex2div_dividend_i : 32'hFFFF_FFFF;
                        rd_out_d = ex2div_rd_addr_i;
                        state_d  = DONE;
                    end else if (overflow) begin
                        result_d = in_rem ? 32'd0 : 32'h8000_0000;
                        rd_out_d = ex2div_rd_addr_i;
                        state_d  = DONE;
                    end else begin
                        quot_d     = a_mag;
                        rem_d      = 32'd0;
                        divisor_d  = b_mag;
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        cnt_d      = 6'd32;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (ex2div_flush_i) begin
                    state_d = IDLE;
                end else begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                    cnt_d  = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        result_d = is_rem_q ? final_rem : final_quot;
                        rd_out_d = rd_q;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            divisor_q  <= 32'd0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rd_q       <= 5'd0;
            result_q   <= 32'd0;
            rd_out_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    // A flush landing in DONE suppresses the pulse in that same cycle.
    assign div2ex_busy_o    = (state_q == CALC);
    assign div2ex_ready_o   = (state_q == DONE) && !ex2div_flush_i;
    assign div2ex_result_o  = result_q;
    assign div2ex_rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: arithmetic vectors, bypass latencies, flush, stall and reset behaviour.
module tb_ex_div;

    logic        clk;
    logic        rest;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    ex_div dut (
        .clk               (clk),
        .rest              (rest),
        .ex2div_start_i    (start_i),
        .ex2div_op_i       (op_i),
        .ex2div_dividend_i (dividend_i),
        .ex2div_divisor_i  (divisor_i),
        .ex2div_rd_addr_i  (rd_i),
        .ex2div_flush_i    (flush_i),
        .div2ex_busy_o     (busy_o),
        .div2ex_ready_o    (ready_o),
        .div2ex_result_o   (result_o),
        .div2ex_rd_addr_o  (rd_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_i       = rd;
    endtask

    // Launch one operation and follow it to its ready pulse; lat counts rising edges from start.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic seen;
        logic busy_ok;
        @(negedge clk);
        drive_start(op, a, b, rd);
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            @(negedge clk);
            start_i = 1'b0;
            lat++;
            if (ready_o) seen = 1'b1;
            else if (!busy_o) busy_ok = 1'b0;
        end
        $display("op=%0d a=0x%08h b=0x%08h rd=%0d -> result=0x%08h rd_o=%0d lat=%0d",
                 op, a, b, rd, result_o, rd_o, lat);
        check_eq({tag, "_ready"}, 32'(seen), 32'd1);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_at_ready"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_busy_in_flight"}, 32'(busy_ok), 32'd1);
        check_eq({tag, "_result"}, result_o, exp_res);
        check_eq({tag, "_rd"}, 32'(rd_o), 32'(rd));
        @(negedge clk);
        check_eq({tag, "_single_pulse"}, 32'(ready_o), 32'd0);
        check_eq({tag, "_hold"}, result_o, exp_res);
    endtask

    initial begin
        int pulses;
        int ready_at;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        logic        busy_after;

        rest = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = 32'd0;
        divisor_i = 32'd0; rd_i = 5'd0; flush_i = 1'b0;
        #2 rest = 1'b0;
        #1;
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_ready", 32'(ready_o), 32'd0);
        check_eq("reset_result", result_o, 32'd0);
        check_eq("reset_rd", 32'(rd_o), 32'd0);
        repeat (2) @(negedge clk);
        rest = 1'b1;

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 33);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
        do_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd1, 32'hFFFF_FFF2, 33);
        do_op("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd2, 32'hFFFF_FFFE, 33);
        do_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33);
        do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1);
        do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 1);
        do_op("rem_m7_0", OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd8, 32'hFFFF_FFF9, 1);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);

        // Flush on the 10th CALC cycle.
        @(negedge clk);
        drive_start(OP_DIVU, 32'd1000, 32'd3, 5'd20);
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("flush_busy_before", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flush_busy_after", 32'(busy_o), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        $display("flush: ready pulses in 40 cycles=%0d", pulses);
        check_eq("flush_no_ready", 32'(pulses), 32'd0);
        do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 33);

        // Start together with flush in IDLE is discarded.
        @(negedge clk);
        drive_start(OP_DIVU, 32'd5, 32'd0, 5'd4);
        flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        $display("start+flush in IDLE: busy=%0d ready=%0d", busy_o, ready_o);
        check_eq("idle_flush_busy", 32'(busy_o), 32'd0);
        check_eq("idle_flush_ready", 32'(ready_o), 32'd0);

        // Repeated starts while busy, plus a start during the DONE cycle.
        @(negedge clk);
        drive_start(OP_DIVU, 32'd100, 32'd7, 5'd3);
        pulses = 0; ready_at = 0; got_res = 32'd0; got_rd = 5'd0; busy_after = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (ready_at != 0 && i == ready_at + 1) busy_after = busy_o;
            if (ready_o) begin
                pulses++;
                ready_at = i;
                got_res  = result_o;
                got_rd   = rd_o;
            end
            if (ready_o || (i % 4 == 0 && i < 30)) drive_start(OP_DIVU, 32'd50, 32'd5, 5'd9);
            else start_i = 1'b0;
        end
        start_i = 1'b0;
        $display("stall: pulses=%0d at=%0d result=0x%08h rd=%0d", pulses, ready_at, got_res, got_rd);
        check_eq("stall_pulses", 32'(pulses), 32'd1);
        check_eq("stall_latency", 32'(ready_at), 32'd33);
        check_eq("stall_result", got_res, 32'd14);
        check_eq("stall_rd", 32'(got_rd), 32'd3);
        check_eq("done_start_ignored", 32'(busy_after), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        drive_start(OP_DIVU, 32'd100, 32'd7, 5'd17);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #1 rest = 1'b0;
        #1;
        $display("mid-calc reset: busy=%0d ready=%0d result=0x%08h rd=%0d", busy_o, ready_o, result_o, rd_o);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_ready", 32'(ready_o), 32'd0);
        check_eq("arst_result", result_o, 32'd0);
        check_eq("arst_rd", 32'(rd_o), 32'd0);
        @(negedge clk);
        rest = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check_eq("arst_no_ready", 32'(pulses), 32'd0);
        do_op("divu_8_2", OP_DIVU, 32'd8, 32'd2, 5'd22, 32'd4, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
